// File: rtl/l1_cache_2way.sv
// Two-way set-associative, write-back, write-allocate L1 cache with one
// pseudo-LRU bit per set and hit/miss counters, fronting a 128-bit block memory.
module l1_cache_2way #(
    parameter int ADDR_W   = 30,
    parameter int SET_BITS = 2,
    parameter int TAG_W    = ADDR_W - 2 - SET_BITS
) (
    input  logic                clk,
    input  logic                proc_reset_n,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic                proc_stall,
    output logic [31:0]         proc_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic [127:0]        mem_rdata,
    input  logic                mem_ready,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);
    localparam int SETS = 1 << SET_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_valid [SETS];
    logic [1:0]          r_dirty [SETS];
    logic [TAG_W-1:0]    r_tag   [2][SETS];
    logic [127:0]        r_data  [2][SETS];
    logic [SETS-1:0]     r_lru;
    logic                r_victim;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_off;
    logic                w_req;
    logic [1:0]          w_hit_way;
    logic                w_hit;
    logic                w_hway;
    logic                w_vict;
    logic                w_idle_hit;
    logic                w_idle_miss;
    logic [127:0]        w_hline;
    logic [127:0]        w_wline;

    assign w_set      = proc_addr[SET_BITS+1:2];
    assign w_tag      = proc_addr[ADDR_W-1:SET_BITS+2];
    assign w_off      = proc_addr[1:0];
    assign w_req      = proc_read | proc_write;
    assign w_hit_way[0] = r_valid[w_set][0] && (r_tag[0][w_set] == w_tag);
    assign w_hit_way[1] = r_valid[w_set][1] && (r_tag[1][w_set] == w_tag);
    assign w_hit      = |w_hit_way;
    assign w_hway     = w_hit_way[1];
    // Fill an empty way first (way 0 wins), otherwise evict the LRU way.
    assign w_vict     = !r_valid[w_set][0] ? 1'b0 :
                        !r_valid[w_set][1] ? 1'b1 : r_lru[w_set];
    assign w_idle_hit  = (r_state == S_IDLE) && w_req && w_hit;
    assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;
    assign w_hline    = r_data[w_hway][w_set];

    always_comb begin
        w_wline = w_hline;
        w_wline[{w_off, 5'b0} +: 32] = proc_wdata;
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) r_state <= S_IDLE;
        else               r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[ADDR_W-1:2];
        mem_wdata  = 128'd0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (!proc_write) proc_rdata = w_hline[{w_off, 5'b0} +: 32];
                    end else begin
                        proc_stall = 1'b1;
                        w_next = (r_valid[w_set][w_vict] && r_dirty[w_set][w_vict]) ? S_WB : S_ALLOC;
                    end
                end
            end
            S_WB: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {r_tag[r_victim][w_set], w_set};
                mem_wdata  = r_data[r_victim][w_set];
                if (mem_ready) w_next = S_ALLOC;
            end
            S_ALLOC: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < 2; w++) begin
                    r_tag[w][s]  <= '0;
                    r_data[w][s] <= '0;
                end
            end
            r_lru      <= '0;
            r_victim   <= 1'b0;
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else begin
            if (w_idle_hit) begin
                r_hit_cnt    <= r_hit_cnt + 32'd1;
                r_lru[w_set] <= ~w_hway;
                if (proc_write) begin
                    r_data[w_hway][w_set]  <= w_wline;
                    r_dirty[w_set][w_hway] <= 1'b1;
                end
            end
            if (w_idle_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
                r_victim   <= w_vict;
            end
            // Fill leaves LRU alone; the retried access in IDLE updates it as a hit.
            if (r_state == S_ALLOC && mem_ready) begin
                r_data[r_victim][w_set]   <= mem_rdata;
                r_tag[r_victim][w_set]    <= w_tag;
                r_valid[w_set][r_victim]  <= 1'b1;
                r_dirty[w_set][r_victim]  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l1_cache_2way.sv
// Randomised scoreboard bench for l1_cache_2way: a transaction-level cache model
// predicts read data, stall length and memory traffic; monitors compare.
module tb_l1_cache_2way;
    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    always #5 clk = ~clk;

    l1_cache_2way #(.ADDR_W(30), .SET_BITS(2)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read),
        .proc_write(proc_write), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_stall(proc_stall), .proc_rdata(proc_rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
    );

    typedef struct { bit wr; logic [27:0] addr; logic [127:0] data; int dly; } op_t;
    typedef struct { bit rd; logic [31:0] rdata; int stalls; } sb_t;
    typedef struct { bit v; bit d; logic [25:0] tag; logic [31:0] w [4]; } mline_t;

    op_t    opq[$];
    sb_t    sbq[$];
    mline_t mc [4][2];
    bit     mlru [4];
    int     m_hits, m_misses;
    int     g_dly;
    logic [127:0] m_img [logic [27:0]];
    logic [127:0] r_img [logic [27:0]];
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] blk_init(input logic [27:0] b);
        logic [127:0] v;
        for (int w = 0; w < 4; w++) v[w*32 +: 32] = {b, 4'b0} + 32'(w) + 32'd1;
        return v;
    endfunction

    function automatic int pick_dly();
        return (g_dly >= 0) ? g_dly : int'($urandom_range(0, 5));
    endfunction

    function automatic logic [29:0] mk(input logic [25:0] t, input int s, input int o);
        return {t, 2'(s), 2'(o)};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mlru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                mc[s][w].v = 1'b0;
                mc[s][w].d = 1'b0;
                mc[s][w].tag = '0;
                for (int k = 0; k < 4; k++) mc[s][w].w[k] = '0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    // One processor access at transaction level: returns what the processor
    // should observe and queues the block traffic the miss must generate.
    task automatic model_access(input logic [29:0] a, input bit wr, input logic [31:0] wd);
        int s;
        int o;
        int way;
        int st;
        logic [25:0] t;
        logic [31:0] rd;
        logic [127:0] blk;
        op_t op;
        sb_t e;
        s = int'(a[3:2]);
        o = int'(a[1:0]);
        t = a[29:4];
        way = -1;
        st = 0;
        rd = '0;
        for (int i = 0; i < 2; i++)
            if (mc[s][i].v && mc[s][i].tag == t) way = i;
        if (way < 0) begin
            m_misses++;
            st = 1;
            if (!mc[s][0].v) way = 0;
            else if (!mc[s][1].v) way = 1;
            else way = int'(mlru[s]);
            if (mc[s][way].v && mc[s][way].d) begin
                for (int k = 0; k < 4; k++) blk[k*32 +: 32] = mc[s][way].w[k];
                op.wr = 1'b1; op.addr = {mc[s][way].tag, 2'(s)}; op.data = blk; op.dly = pick_dly();
                opq.push_back(op);
                st += op.dly + 1;
                m_img[op.addr] = blk;
            end
            op.wr = 1'b0; op.addr = a[29:2]; op.data = '0; op.dly = pick_dly();
            opq.push_back(op);
            st += op.dly + 1;
            blk = m_img.exists(a[29:2]) ? m_img[a[29:2]] : blk_init(a[29:2]);
            mc[s][way].v = 1'b1;
            mc[s][way].d = 1'b0;
            mc[s][way].tag = t;
            for (int k = 0; k < 4; k++) mc[s][way].w[k] = blk[k*32 +: 32];
        end
        m_hits++;
        if (wr) begin
            mc[s][way].w[o] = wd;
            mc[s][way].d = 1'b1;
        end else begin
            rd = mc[s][way].w[o];
        end
        mlru[s] = (way == 0);
        e.rd = !wr; e.rdata = rd; e.stalls = st;
        sbq.push_back(e);
    endtask

    // mode: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic do_access(input logic [29:0] a, input int mode);
        logic [31:0] wd;
        int n;
        wd = $urandom;
        model_access(a, mode != 0, wd);
        proc_addr  = a;
        proc_wdata = wd;
        proc_read  = (mode != 1);
        proc_write = (mode != 0);
        n = 0;
        forever begin
            @(negedge clk);
            if (!proc_stall) break;
            n++;
            if (n > 300) begin
                chk("access_complete", proc_stall, 1'b0);
                sbq.delete();
                opq.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
    endtask

    // Processor-side monitor
    initial begin
        int scnt;
        sb_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (!proc_reset_n) begin
                scnt = 0;
            end else if (proc_read || proc_write) begin
                if (proc_stall) begin
                    scnt++;
                end else begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_completion", proc_stall, 1'b1);
                    end else begin
                        e = sbq.pop_front();
                        chk(e.rd ? "read_data" : "rdata_on_write", proc_rdata, e.rdata);
                        chk("stall_cycles", scnt, e.stalls);
                    end
                    scnt = 0;
                end
            end
        end
    end

    // Block memory responder and memory-side monitor
    initial begin
        bit   busy;
        bit   cur_wr;
        int   cnt;
        op_t  cur;
        logic [27:0] cur_addr;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!proc_reset_n || !(mem_read || mem_write)) begin
                busy = 1'b0;
                continue;
            end
            if (!busy) begin
                chk("mem_rw_exclusive", mem_read & mem_write, 1'b0);
                if (opq.size() == 0) begin
                    chk("unexpected_mem_op", {mem_read, mem_write}, 2'b00);
                    cur.wr = mem_write; cur.addr = mem_addr; cur.data = mem_wdata; cur.dly = 0;
                end else begin
                    cur = opq.pop_front();
                    chk("mem_op_kind", mem_write, cur.wr);
                    chk("mem_addr", mem_addr, cur.addr);
                    if (cur.wr) chk("mem_wdata", mem_wdata, cur.data);
                end
                busy = 1'b1;
                cnt = 0;
                cur_addr = mem_addr;
                cur_wr = mem_write;
            end else begin
                chk("mem_addr_stable", mem_addr, cur_addr);
                chk("mem_op_stable", mem_write, cur_wr);
                cnt++;
            end
            if (cnt >= cur.dly) begin
                if (cur_wr) r_img[mem_addr] = mem_wdata;
                else mem_rdata = r_img.exists(mem_addr) ? r_img[mem_addr] : blk_init(mem_addr);
                mem_ready = 1'b1;
                busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [29:0] a;
        int n;
        model_reset();
        g_dly = 0;

        #1 proc_reset_n = 1'b0;
        proc_addr = 30'h12345678;
        #2;
        chk("rst_stall_idle", proc_stall, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 28'h48D159E);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        chk("rst_rdata", proc_rdata, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        proc_read = 1'b1;
        #1;
        chk("rst_stall_req", proc_stall, 1'b1);
        proc_read = 1'b0;
        @(negedge clk);
        #2 proc_reset_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(mk(26'd0, 0, 0), 0);
        do_access(mk(26'd1, 0, 1), 0);
        do_access(mk(26'd0, 0, 3), 0);
        do_access(mk(26'd2, 0, 2), 0);
        do_access(mk(26'd0, 0, 2), 1);
        do_access(mk(26'd3, 0, 0), 0);
        do_access(mk(26'd4, 0, 0), 0);
        do_access(mk(26'd5, 1, 1), 1);
        do_access(mk(26'd5, 1, 1), 0);
        do_access(mk(26'd6, 1, 0), 0);
        do_access(mk(26'd7, 1, 0), 0);
        g_dly = 5;
        do_access(mk(26'd0, 2, 0), 1);
        do_access(mk(26'd1, 2, 0), 0);
        do_access(mk(26'd2, 2, 3), 0);
        do_access(mk(26'h3FFFFFF, 3, 3), 2);

        g_dly = -1;
        for (int i = 0; i < 300; i++) begin
            logic [25:0] tg;
            case ($urandom_range(0, 4))
                0: tg = 26'd0;
                1: tg = 26'd1;
                2: tg = 26'd2;
                3: tg = 26'd3;
                default: tg = 26'h3FFFFFF;
            endcase
            do_access(mk(tg, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                      int'($urandom_range(0, 2)));
        end

        g_dly = 5;
        a = mk(26'd9, 3, 1);
        model_access(a, 1'b0, 32'd0);
        proc_addr = a;
        proc_read = 1'b1;
        n = 0;
        while (!mem_read && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("alloc_reached", mem_read, 1'b1);
        #2 proc_reset_n = 1'b0;
        #1;
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_mem_write", mem_write, 1'b0);
        chk("abort_stall", proc_stall, 1'b1);
        sbq.delete();
        opq.delete();
        model_reset();
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_hit_cnt", hit_cnt, 32'd0);
        chk("abort_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        #2 proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
        g_dly = 0;
        do_access(a, 0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
